// File: rtl/operand_bank_writer.sv
// operand_bank_writer
// Converts a row-major element stream of an R x C operand matrix into
// per-bank one-hot write enables, a shared bank-local address and a
// registered data copy. ROW mode spreads matrix rows across banks. COL mode
// spreads matrix columns across banks, which stores the transpose.
// Addresses are built incrementally; no multiply or divide is used.
module operand_bank_writer #(
   parameter int NBANK        = 4,
   parameter int MATRIXSIZE_W = 16,
   parameter int ADDR_W       = 12,
   parameter int DATA_W       = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    cfg_mode,
   input  logic [MATRIXSIZE_W-1:0] cfg_rows,
   input  logic [MATRIXSIZE_W-1:0] cfg_cols,
   input  logic [ADDR_W-1:0]       cfg_base,
   input  logic                    in_valid,
   input  logic [DATA_W-1:0]       in_data,
   output logic                    in_ready,
   output logic [NBANK-1:0]        wr_en,
   output logic [ADDR_W-1:0]       wr_addr,
   output logic [DATA_W-1:0]       wr_data,
   output logic                    busy,
   output logic                    done
);

   localparam int BANK_W = (NBANK > 1) ? $clog2(NBANK) : 1;
   localparam logic [BANK_W-1:0] BANK_LAST = BANK_W'(NBANK - 1);

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   state_t                  state_reg, state_next;

   // Frame configuration captured on an accepted start
   logic                    mode_reg;
   logic [MATRIXSIZE_W-1:0] rows_reg, cols_reg;
   logic [ADDR_W-1:0]       base_reg;

   // Position and address-generation counters
   logic [MATRIXSIZE_W-1:0] r_cnt_reg, r_cnt_next;
   logic [MATRIXSIZE_W-1:0] c_cnt_reg, c_cnt_next;
   logic [BANK_W-1:0]       bank_reg, bank_next;
   logic [ADDR_W-1:0]       goff_reg, goff_next;

   // Registered write port
   logic [NBANK-1:0]        wr_en_reg, wr_en_next;
   logic [ADDR_W-1:0]       wr_addr_reg;
   logic [DATA_W-1:0]       wr_data_reg;
   logic                    done_reg, done_next;

   logic                    start_ok, zero_size, accept;
   logic                    last_col, last_row, last_elem;
   logic [ADDR_W-1:0]       rows_a, cols_a, local_a, addr_cur;

   assign start_ok  = start && (state_reg == IDLE);
   assign zero_size = (cfg_rows == '0) || (cfg_cols == '0);
   assign accept    = in_valid && (state_reg == BUSY);
   assign last_col  = (c_cnt_reg == cols_reg - MATRIXSIZE_W'(1));
   assign last_row  = (r_cnt_reg == rows_reg - MATRIXSIZE_W'(1));
   assign last_elem = last_col && last_row;

   // Dimensions and the in-group index reduced to address width; the
   // arithmetic wraps modulo 2^ADDR_W by construction.
   assign rows_a   = ADDR_W'(rows_reg);
   assign cols_a   = ADDR_W'(cols_reg);
   assign local_a  = mode_reg ? ADDR_W'(r_cnt_reg) : ADDR_W'(c_cnt_reg);
   assign addr_cur = base_reg + goff_reg + local_a;

   // One-hot bank decode of the current element, gated by the handshake
   generate
      for (genvar gi = 0; gi < NBANK; gi++) begin : g_bank_sel
         assign wr_en_next[gi] = accept && (bank_reg == BANK_W'(gi));
      end
   endgenerate

   // Frame ends on the last accept, or straight away for an empty matrix
   assign done_next = (start_ok && zero_size) || (accept && last_elem);

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic: empty frames never leave IDLE
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (start && !zero_size) state_next = BUSY;
         BUSY:    if (accept && last_elem) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      in_ready = (state_reg == BUSY);
      busy     = (state_reg == BUSY);
   end

   // Counter advance: ROW mode rotates the bank per matrix row and bumps the
   // group offset by C on a bank wrap; COL mode rotates the bank per element,
   // bumps the offset by R on a wrap, and restarts both at each row end.
   always_comb begin
      r_cnt_next = r_cnt_reg;
      c_cnt_next = c_cnt_reg;
      bank_next  = bank_reg;
      goff_next  = goff_reg;
      if (start_ok) begin
         r_cnt_next = '0;
         c_cnt_next = '0;
         bank_next  = '0;
         goff_next  = '0;
      end else if (accept) begin
         if (!mode_reg) begin
            if (last_col) begin
               c_cnt_next = '0;
               r_cnt_next = r_cnt_reg + MATRIXSIZE_W'(1);
               if (bank_reg == BANK_LAST) begin
                  bank_next = '0;
                  goff_next = goff_reg + cols_a;
               end else begin
                  bank_next = bank_reg + BANK_W'(1);
               end
            end else begin
               c_cnt_next = c_cnt_reg + MATRIXSIZE_W'(1);
            end
         end else begin
            if (last_col) begin
               c_cnt_next = '0;
               r_cnt_next = r_cnt_reg + MATRIXSIZE_W'(1);
               bank_next  = '0;
               goff_next  = '0;
            end else begin
               c_cnt_next = c_cnt_reg + MATRIXSIZE_W'(1);
               if (bank_reg == BANK_LAST) begin
                  bank_next = '0;
                  goff_next = goff_reg + rows_a;
               end else begin
                  bank_next = bank_reg + BANK_W'(1);
               end
            end
         end
      end
   end

   // Counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt_reg <= '0;
         c_cnt_reg <= '0;
         bank_reg  <= '0;
         goff_reg  <= '0;
      end else begin
         r_cnt_reg <= r_cnt_next;
         c_cnt_reg <= c_cnt_next;
         bank_reg  <= bank_next;
         goff_reg  <= goff_next;
      end
   end

   // Capture the frame configuration only when a start is honoured
   always_ff @(posedge clk) begin
      if (rst) begin
         mode_reg <= 1'b0;
         rows_reg <= '0;
         cols_reg <= '0;
         base_reg <= '0;
      end else if (start_ok) begin
         mode_reg <= cfg_mode;
         rows_reg <= cfg_rows;
         cols_reg <= cfg_cols;
         base_reg <= cfg_base;
      end
   end

   // Write port register: one cycle after each accept; address and data hold
   // between writes while the enable drops back to zero
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_en_reg   <= '0;
         wr_addr_reg <= '0;
         wr_data_reg <= '0;
         done_reg    <= 1'b0;
      end else begin
         wr_en_reg <= wr_en_next;
         done_reg  <= done_next;
         if (accept) begin
            wr_addr_reg <= addr_cur;
            wr_data_reg <= in_data;
         end
      end
   end

   assign wr_en   = wr_en_reg;
   assign wr_addr = wr_addr_reg;
   assign wr_data = wr_data_reg;
   assign done    = done_reg;

endmodule

// File: tb/tb_operand_bank_writer.sv
// tb_operand_bank_writer
// Directed frame sequence with randomized valid gaps and data. Expected
// writes come from the closed-form bank/address map (division and modulo
// on the element coordinates) evaluated per accepted element.
module tb_operand_bank_writer;

   localparam int NB = 4;
   localparam int MW = 16;
   localparam int AW = 12;
   localparam int DW = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, start, cfg_mode, in_valid, sel4;
   logic [MW-1:0] cfg_rows, cfg_cols;
   logic [AW-1:0] cfg_base;
   logic [DW-1:0] in_data;
   logic          start_a, start_b;

   logic          rdy_a, busy_a, done_a;
   logic [NB-1:0] en_a;
   logic [AW-1:0] addr_a;
   logic [DW-1:0] data_a;

   logic          rdy_b, busy_b, done_b;
   logic [NB-1:0] en_b;
   logic [3:0]    addr_b;
   logic [DW-1:0] data_b;

   assign start_a = start && !sel4;
   assign start_b = start && sel4;

   operand_bank_writer #(.NBANK(NB), .MATRIXSIZE_W(MW), .ADDR_W(AW), .DATA_W(DW)) u_dut (
      .clk(clk), .rst(rst), .start(start_a), .cfg_mode(cfg_mode),
      .cfg_rows(cfg_rows), .cfg_cols(cfg_cols), .cfg_base(cfg_base),
      .in_valid(in_valid), .in_data(in_data), .in_ready(rdy_a),
      .wr_en(en_a), .wr_addr(addr_a), .wr_data(data_a),
      .busy(busy_a), .done(done_a)
   );

   // Narrow-address instance for the wrap-around case
   operand_bank_writer #(.NBANK(NB), .MATRIXSIZE_W(MW), .ADDR_W(4), .DATA_W(DW)) u_dut4 (
      .clk(clk), .rst(rst), .start(start_b), .cfg_mode(cfg_mode),
      .cfg_rows(cfg_rows), .cfg_cols(cfg_cols), .cfg_base(cfg_base[3:0]),
      .in_valid(in_valid), .in_data(in_data), .in_ready(rdy_b),
      .wr_en(en_b), .wr_addr(addr_b), .wr_data(data_b),
      .busy(busy_b), .done(done_b)
   );

   typedef struct {
      logic [31:0] en;
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   wr_t obs_q[$];
   wr_t ref_q[$];

   int n_vec = 0;
   int n_err = 0;

   // Reference model state
   bit          m_busy, m_mode;
   int          m_R, m_C, m_base, m_r, m_c;
   int          aw_mask, n_acc, salt;
   logic [31:0] exp_en, exp_addr, exp_data;
   bit          exp_done, exp_zero;
   int          cnt[NB][8];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock: predict the outputs from the current inputs, then
   // compare what the selected instance shows after the edge.
   task automatic cycle();
      int          bank, loc;
      logic [31:0] o_en, o_addr, o_data, o_busy, o_rdy, o_done;
      exp_en   = '0;
      exp_done = 1'b0;
      exp_zero = 1'b0;
      if (rst) begin
         m_busy   = 1'b0;
         exp_zero = 1'b1;
      end else if (!m_busy && start) begin
         m_mode = cfg_mode;
         m_R    = int'(cfg_rows);
         m_C    = int'(cfg_cols);
         m_base = sel4 ? int'(cfg_base[3:0]) : int'(cfg_base);
         if (m_R == 0 || m_C == 0) begin
            exp_done = 1'b1;
         end else begin
            m_busy = 1'b1;
            m_r    = 0;
            m_c    = 0;
         end
      end else if (m_busy && in_valid) begin
         bank = m_mode ? (m_c % NB) : (m_r % NB);
         loc  = m_mode ? ((m_c / NB) * m_R + m_r) : ((m_r / NB) * m_C + m_c);
         exp_en[bank] = 1'b1;
         exp_addr = 32'((m_base + loc) & aw_mask);
         exp_data = 32'(in_data);
         n_acc++;
         if (m_c == m_C - 1) begin
            m_c = 0;
            if (m_r == m_R - 1) begin
               m_busy   = 1'b0;
               exp_done = 1'b1;
            end else begin
               m_r++;
            end
         end else begin
            m_c++;
         end
      end
      @(posedge clk);
      #1;
      o_en   = sel4 ? 32'(en_b)   : 32'(en_a);
      o_addr = sel4 ? 32'(addr_b) : 32'(addr_a);
      o_data = sel4 ? 32'(data_b) : 32'(data_a);
      o_busy = sel4 ? 32'(busy_b) : 32'(busy_a);
      o_rdy  = sel4 ? 32'(rdy_b)  : 32'(rdy_a);
      o_done = sel4 ? 32'(done_b) : 32'(done_a);
      if (o_en !== 32'd0) obs_q.push_back('{en: o_en, addr: o_addr, data: o_data});
      chk("wr_en", o_en, exp_en);
      chk("done", o_done, 32'(exp_done));
      chk("busy", o_busy, 32'(m_busy));
      chk("in_ready", o_rdy, 32'(m_busy));
      if (exp_zero) begin
         chk("rst_addr", o_addr, 32'd0);
         chk("rst_data", o_data, 32'd0);
      end else if (exp_en != 32'd0) begin
         chk("wr_addr", o_addr, exp_addr);
         chk("wr_data", o_data, exp_data);
      end
      $display("t=%0t en=%0h addr=%0h data=%0h busy=%0d done=%0d", $time, o_en, o_addr, o_data, o_busy, o_done);
   endtask

   // Start a frame and feed it until it completes or max_acc elements are taken
   task automatic run_frame(input bit mode, input int rows, input int cols, input int base,
                            input int duty, input int max_acc, input bit mid_start);
      obs_q.delete();
      n_acc    = 0;
      cfg_mode = mode;
      cfg_rows = MW'(rows);
      cfg_cols = MW'(cols);
      cfg_base = AW'(base);
      in_valid = 1'b0;
      start    = 1'b1;
      cycle();
      start = 1'b0;
      for (int k = 0; k < 2000 && m_busy && n_acc < max_acc; k++) begin
         cfg_mode = 1'($urandom);
         cfg_rows = MW'($urandom_range(1, 9));
         cfg_cols = MW'($urandom_range(1, 9));
         cfg_base = AW'($urandom);
         start    = mid_start && (k == 3);
         in_valid = ($urandom_range(99) < duty);
         in_data  = in_valid ? DW'(m_r * m_C + m_c + salt) : DW'($urandom);
         cycle();
      end
      start    = 1'b0;
      in_valid = 1'b0;
      chk("frame_bound", 32'(m_busy && n_acc < max_acc), 32'd0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; sel4 = 1'b0; in_valid = 1'b0; in_data = '0;
      cfg_mode = 1'b0; cfg_rows = '0; cfg_cols = '0; cfg_base = '0;
      m_busy = 1'b0; salt = 0; aw_mask = 32'hFFF; n_acc = 0;
      cycle();
      cycle();
      rst = 1'b0;
      cycle();

      // ROW distribution, 8x3, base 0x010
      run_frame(1'b0, 8, 3, 'h010, 100, 1000, 1'b0);
      chk("row_count", 32'(obs_q.size()), 32'd24);
      if (obs_q.size() == 24) begin
         chk("row_e52_en", obs_q[17].en, 32'b0010);
         chk("row_e52_addr", obs_q[17].addr, 32'h015);
      end
      cycle();

      // COL distribution, 3x8, full bank/address scoreboard
      run_frame(1'b1, 3, 8, 0, 100, 1000, 1'b0);
      chk("col_count", 32'(obs_q.size()), 32'd24);
      if (obs_q.size() == 24) begin
         chk("col_e25_en", obs_q[21].en, 32'b0010);
         chk("col_e25_addr", obs_q[21].addr, 32'd5);
      end
      foreach (cnt[b, a]) cnt[b][a] = 0;
      foreach (obs_q[i]) begin
         for (int b = 0; b < NB; b++) begin
            if (obs_q[i].en[b] === 1'b1 && obs_q[i].addr < 8) cnt[b][obs_q[i].addr]++;
         end
      end
      for (int b = 0; b < NB; b++) begin
         for (int a = 0; a < 6; a++) chk($sformatf("col_map_b%0d_a%0d", b, a), 32'(cnt[b][a]), 32'd1);
      end

      // Same ROW frame without and with valid gaps must write identically
      salt = 7;
      run_frame(1'b0, 4, 5, 'h020, 100, 1000, 1'b0);
      ref_q = obs_q;
      run_frame(1'b0, 4, 5, 'h020, 40, 1000, 1'b0);
      chk("gap_count", 32'(obs_q.size()), 32'(ref_q.size()));
      if (obs_q.size() == ref_q.size()) begin
         foreach (ref_q[i]) begin
            chk("gap_en", obs_q[i].en, ref_q[i].en);
            chk("gap_addr", obs_q[i].addr, ref_q[i].addr);
            chk("gap_data", obs_q[i].data, ref_q[i].data);
         end
      end

      // Zero rows: done only, no busy, no writes even with valid held high
      run_frame(1'b0, 0, 7, 0, 100, 1000, 1'b0);
      in_valid = 1'b1;
      repeat (3) cycle();
      in_valid = 1'b0;
      chk("zero_writes", 32'(obs_q.size()), 32'd0);

      // Mid-frame start ignored, then back-to-back frame started in done cycle
      salt = 3;
      run_frame(1'b0, 4, 3, 'h100, 70, 1000, 1'b1);
      run_frame(1'b1, 5, 4, 'h200, 100, 1000, 1'b0);
      chk("b2b_count", 32'(obs_q.size()), 32'd20);
      if (obs_q.size() > 0) begin
         chk("b2b_first_en", obs_q[0].en, 32'b0001);
         chk("b2b_first_addr", obs_q[0].addr, 32'h200);
      end

      // Reset after 10 accepts, then a 2x2 ROW frame
      salt = 0;
      run_frame(1'b0, 8, 3, 0, 100, 10, 1'b0);
      chk("pre_rst_acc", 32'(n_acc), 32'd10);
      rst      = 1'b1;
      in_valid = 1'b1;
      cycle();
      rst      = 1'b0;
      in_valid = 1'b0;
      cycle();
      run_frame(1'b0, 2, 2, 0, 100, 1000, 1'b0);
      chk("post_rst_count", 32'(obs_q.size()), 32'd4);
      if (obs_q.size() == 4) begin
         chk("post_rst_w0", {obs_q[0].en[15:0], obs_q[0].addr[15:0]}, {16'd1, 16'd0});
         chk("post_rst_w1", {obs_q[1].en[15:0], obs_q[1].addr[15:0]}, {16'd1, 16'd1});
         chk("post_rst_w2", {obs_q[2].en[15:0], obs_q[2].addr[15:0]}, {16'd2, 16'd0});
         chk("post_rst_w3", {obs_q[3].en[15:0], obs_q[3].addr[15:0]}, {16'd2, 16'd1});
      end

      // Narrow address: base 0xE wraps to 0 for element (0,2)
      sel4    = 1'b1;
      aw_mask = 32'hF;
      cycle();
      run_frame(1'b0, 4, 3, 'hE, 100, 1000, 1'b0);
      chk("wrap_count", 32'(obs_q.size()), 32'd12);
      if (obs_q.size() == 12) chk("wrap_e02_addr", obs_q[2].addr, 32'h0);
      sel4    = 1'b0;
      aw_mask = 32'hFFF;
      cycle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
